// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle: serial line and frame options in, recovered word and strobes out.
// DATA_VALID is a one-cycle push strobe with no backpressure (no ready); P_DATA is valid with it and holds until the next good frame.
interface uart_rx_core_if #(
  parameter int WIDTH = 8
);
  logic             RX_IN;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_ERR;
  logic             STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled at PRESCALE x bit rate, 2-of-3 mid-bit vote, LSB-first,
// optional even/odd parity, one stop bit, one-cycle result strobes.
module uart_rx_core #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_core_if.slave  bus,
  output logic [2:0]     dbg_state
);

  localparam int EW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [EW-1:0] SMP0 = EW'(PRESCALE/2 - 1);
  localparam logic [EW-1:0] SMP1 = EW'(PRESCALE/2);
  localparam logic [EW-1:0] SMP2 = EW'(PRESCALE/2 + 1);
  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
  // Early stop decision; clamped so the smallest prescale still reaches it inside the bit.
  localparam logic [EW-1:0] STOP_AT =
    EW'((PRESCALE/2 + 2 > PRESCALE - 1) ? PRESCALE - 1 : PRESCALE/2 + 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic             rx_meta, rx, rx_prev;
  logic [EW-1:0]    edge_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [2:0]       smp;
  logic [WIDTH-1:0] shift_reg;
  logic             par_en_l, par_typ_l, par_bad;
  logic             smp2_now, maj;

  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx      <= rx_meta;
      rx_prev <= rx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp <= 3'b111;
    end else if (state != IDLE) begin
      if (edge_cnt == SMP0) smp[0] <= rx;
      if (edge_cnt == SMP1) smp[1] <= rx;
      if (edge_cnt == SMP2) smp[2] <= rx;
    end
  end

  // The third sample is bypassed from rx when the decision lands on its capture cycle.
  always_comb begin
    smp2_now = (edge_cnt == SMP2) ? rx : smp[2];
    maj      = (smp[0] & smp[1]) | (smp[0] & smp2_now) | (smp[1] & smp2_now);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      par_en_l       <= 1'b0;
      par_typ_l      <= 1'b0;
      par_bad        <= 1'b0;
      bus.P_DATA     <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
    end else begin
      bus.DATA_VALID <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          // The detect cycle counts as edge 0 of the start bit.
          if (!rx && rx_prev) begin
            state     <= START;
            edge_cnt  <= EW'(1);
            par_en_l  <= bus.PAR_EN;
            par_typ_l <= bus.PAR_TYP;
          end
        end
        START: begin
          edge_cnt <= edge_cnt + EW'(1);
          if (edge_cnt == LAST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            state    <= maj ? IDLE : DATA;
          end
        end
        DATA: begin
          edge_cnt <= edge_cnt + EW'(1);
          if (edge_cnt == LAST) begin
            edge_cnt  <= '0;
            shift_reg <= {maj, shift_reg[WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) state <= par_en_l ? PARITY : STOP;
          end
        end
        PARITY: begin
          edge_cnt <= edge_cnt + EW'(1);
          if (edge_cnt == LAST) begin
            edge_cnt <= '0;
            par_bad  <= (maj != (^shift_reg ^ par_typ_l));
            state    <= STOP;
          end
        end
        STOP: begin
          edge_cnt <= edge_cnt + EW'(1);
          if (edge_cnt == STOP_AT) begin
            if (maj && !par_bad) begin
              bus.P_DATA     <= shift_reg;
              bus.DATA_VALID <= 1'b1;
            end
            bus.PAR_ERR <= par_bad;
            bus.STP_ERR <= ~maj;
            par_bad     <= 1'b0;
            edge_cnt    <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames driven on negedges, strobes sampled on negedges,
// expected words held in a queue and latencies measured from the first clock edge that sees the start bit.
module tb_uart_rx_core;

  localparam int W = 8;
  localparam int P = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  uart_rx_core_if #(.WIDTH(W)) bus ();

  uart_rx_core #(.WIDTH(W), .PRESCALE(P)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           dv_t_q[$];
  int           pe_cnt = 0;
  int           se_cnt = 0;

  always @(negedge clk) begin
    if (bus.DATA_VALID === 1'b1) begin
      got_q.push_back(bus.P_DATA);
      dv_t_q.push_back(cyc);
    end
    if (bus.PAR_ERR === 1'b1) pe_cnt++;
    if (bus.STP_ERR === 1'b1) se_cnt++;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_dv_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
    dv_t_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b, input bit noisy);
    for (int j = 0; j < P; j++) begin
      @(negedge clk);
      bus.RX_IN = (noisy && j == P/2) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit with_par, input logic par_bit,
                            input logic stop_bit, input int noise_bit, output int t_ref);
    @(negedge clk);
    bus.RX_IN = 1'b0;
    t_ref = cyc + 1;
    repeat (P - 1) @(negedge clk);
    for (int i = 0; i < W; i++) drive_bit(d[i], i == noise_bit);
    if (with_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int t0, t1, t2;

  initial begin
    rst_n       = 1'b0;
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p_data", 32'(bus.P_DATA), 0);
    check("rst_dv",     32'(bus.DATA_VALID), 0);
    check("rst_par",    32'(bus.PAR_ERR), 0);
    check("rst_stp",    32'(bus.STP_ERR), 0);
    check("rst_state",  32'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (2*P) @(negedge clk);

    // 0xA5, no parity: latency 2 + 8*9 + 6 = 80
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, t0);
    settle();
    if (dv_t_q.size() > 0) check("a5_latency", 32'(dv_t_q[0] - t0), 80);
    check_sb("a5");
    check("a5_pe", 32'(pe_cnt), 0);
    check("a5_se", 32'(se_cnt), 0);
    check("a5_hold", 32'(bus.P_DATA), 32'h0A5);

    // Even parity, 0x3C has four ones: parity bit 0 is good; latency 88
    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, t0);
    settle();
    if (dv_t_q.size() > 0) check("3c_even_latency", 32'(dv_t_q[0] - t0), 88);
    check_sb("3c_even");
    check("3c_even_pe", 32'(pe_cnt), 0);

    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, t0);
    settle();
    check_sb("3c_badpar");
    check("3c_badpar_pe", 32'(pe_cnt), 1);
    check("3c_badpar_hold", 32'(bus.P_DATA), 32'h03C);

    // 0x3D has five ones, even parity wants 1; sending 0 is an error and P_DATA keeps 0x3C
    send_frame(8'h3D, 1'b1, 1'b0, 1'b1, -1, t0);
    settle();
    check_sb("3d_badpar");
    check("3d_badpar_pe", 32'(pe_cnt), 2);
    check("3d_badpar_hold", 32'(bus.P_DATA), 32'h03C);

    // Odd parity, 0x3C with parity 1 is good; options flipped mid-frame must be ignored
    bus.PAR_TYP = 1'b1;
    exp_q.push_back(8'h3C);
    fork
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, t0);
      begin
        repeat (20) @(negedge clk);
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
      end
    join
    settle();
    check_sb("3c_odd");
    check("3c_odd_pe", 32'(pe_cnt), 2);
    check("3c_odd_se", 32'(se_cnt), 0);

    // Stop bit low on 0x81, then the line stays low for 40 bit times
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, t0);
    settle();
    check_sb("81_stp");
    check("81_stp_se", 32'(se_cnt), 1);
    check("81_stp_hold", 32'(bus.P_DATA), 32'h03C);
    repeat (40*P) @(negedge clk);
    check("break_se", 32'(se_cnt), 1);
    check("break_pe", 32'(pe_cnt), 2);
    check("break_dv", 32'(got_q.size()), 0);
    check("break_state", 32'(dbg_state), 0);
    bus.RX_IN = 1'b1;
    repeat (2*P) @(negedge clk);

    // Start glitch two clocks long: FSM enters START, votes 1 and drops back silently
    @(negedge clk); bus.RX_IN = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.RX_IN = 1'b1;
    @(negedge clk);
    check("glitch_start", 32'(dbg_state), 1);
    repeat (3*P) @(negedge clk);
    check("glitch_idle", 32'(dbg_state), 0);
    check("glitch_dv", 32'(got_q.size()), 0);
    check("glitch_se", 32'(se_cnt), 1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, t0);
    settle();
    if (dv_t_q.size() > 0) check("5a_latency", 32'(dv_t_q[0] - t0), 80);
    check_sb("5a");

    // Back-to-back, odd parity: 0x01->0, 0xFF->1, 0x80->0; noise mid-bit 3 of 0xFF
    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, -1, t0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 3, t1);
    send_frame(8'h80, 1'b1, 1'b0, 1'b1, -1, t2);
    settle();
    if (dv_t_q.size() == 3) begin
      check("b2b_latency", 32'(dv_t_q[0] - t0), 88);
      check("b2b_gap1", 32'(dv_t_q[1] - dv_t_q[0]), 88);
      check("b2b_gap2", 32'(dv_t_q[2] - dv_t_q[1]), 88);
    end
    check_sb("b2b");
    check("b2b_pe", 32'(pe_cnt), 2);
    check("b2b_se", 32'(se_cnt), 1);

    // Reset during the data bits of a frame
    bus.PAR_EN = 1'b0;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_p_data", 32'(bus.P_DATA), 0);
    check("midrst_dv", 32'(bus.DATA_VALID), 0);
    check("midrst_state", 32'(dbg_state), 0);
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2*P) @(negedge clk);
    check("midrst_no_dv", 32'(got_q.size()), 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1, t0);
    settle();
    if (dv_t_q.size() > 0) check("7e_latency", 32'(dv_t_q[0] - t0), 80);
    check_sb("7e");
    check("7e_pe", 32'(pe_cnt), 2);
    check("7e_se", 32'(se_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
